// File: rtl/ccd_sensor_emulator.sv
// rtl/ccd_sensor_emulator.sv - synthetic CMOS sensor source with FVAL/LVAL/10-bit Bayer data
//
// Purpose: generates frames of test patterns (colour bars, ramp, checkerboard, constant) on the
// same interface the capture path consumes. Clk doubles as the pixel clock.
// Optional feature macro: CCD_EMU_CHECKSUM_EN (per-frame 16-bit pixel checksum ports).
//
// Ports:
//   Clk             in   1   system/pixel clock
//   Reset           in   1   asynchronous, active-high reset
//   iEnable         in   1   1 = stream frames, 0 = stop after the current frame
//   iPattern        in   2   0 colour bars, 1 ramp, 2 checkerboard, 3 constant
//   iConst          in   10  pixel value for the constant pattern
//   oDATA           out  10  pixel data, 0 whenever oLVAL=0
//   oFVAL           out  1   frame valid
//   oLVAL           out  1   line valid
//   oBusy           out  1   1 whenever not idle
//   oFrame_Cont     out  32  completed-frame count
//   oChecksum       out  16  (CCD_EMU_CHECKSUM_EN) sum of active pixels of the last frame
//   oChecksum_Valid out  1   (CCD_EMU_CHECKSUM_EN) pulse on the clock oFVAL falls
module ccd_sensor_emulator #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 244,
    parameter int V_ACTIVE = 1024,
    parameter int V_BLANK  = 16,
    parameter int FV_LEAD  = 8,
    parameter int FV_TRAIL = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        iEnable,
    input  logic [1:0]  iPattern,
    input  logic [9:0]  iConst,
    output logic [9:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic        oBusy,
`ifdef CCD_EMU_CHECKSUM_EN
    output logic [15:0] oChecksum,
    output logic        oChecksum_Valid,
`endif
    output logic [31:0] oFrame_Cont
);
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);

    typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, BACK, VBLANK} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] y_q, y_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] bpix_q, bpix_d;
    logic [1:0]  pat_q, pat_d;
    logic [9:0]  cst_q, cst_d;
    logic [9:0]  data_q, data_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic        busy_q, busy_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic        frame_end;
    logic [2:0]  c;
    logic        site_on;
    logic [9:0]  pix;
`ifdef CCD_EMU_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;
    logic        csv_q, csv_d;
`endif

    // Outputs are registered from the next-state values so they line up with state_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        y_d       = y_q;
        bar_d     = bar_q;
        bpix_d    = bpix_q;
        pat_d     = pat_q;
        cst_d     = cst_q;
        fcnt_d    = fcnt_q;
        frame_end = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (iEnable) state_d = FRONT;
            end
            FRONT: begin
                if (cnt_q == 32'(FV_LEAD - 1)) begin
                    state_d = LINE;
                    cnt_d   = 32'd0;
                    y_d     = 16'd0;
                end
            end
            LINE: begin
                if (cnt_q == 32'(H_ACTIVE - 1)) begin
                    cnt_d   = 32'd0;
                    // No horizontal blank after the last line of the frame.
                    state_d = (y_q < 16'(V_ACTIVE - 1)) ? HBLANK : BACK;
                end
            end
            HBLANK: begin
                if (cnt_q == 32'(H_BLANK - 1)) begin
                    state_d = LINE;
                    cnt_d   = 32'd0;
                    y_d     = y_q + 16'd1;
                end
            end
            BACK: begin
                if (cnt_q == 32'(FV_TRAIL - 1)) begin
                    cnt_d     = 32'd0;
                    fcnt_d    = fcnt_q + 32'd1;
                    frame_end = 1'b1;
                    state_d   = iEnable ? VBLANK : IDLE;
                end
            end
            VBLANK: begin
                if (cnt_q == 32'(VB_LEN - 1)) begin
                    cnt_d   = 32'd0;
                    state_d = iEnable ? FRONT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // Pattern selection is frozen for the whole frame.
        if (state_d == FRONT && state_q != FRONT) begin
            pat_d = iPattern;
            cst_d = iConst;
        end

        // Bar index tracked by a sub-counter so x/BAR_W needs no divider.
        if (state_d == LINE) begin
            if (state_q != LINE) begin
                bar_d  = 3'd0;
                bpix_d = 16'd0;
            end else if (bpix_q == 16'(BAR_W - 1)) begin
                bar_d  = bar_q + 3'd1;
                bpix_d = 16'd0;
            end else begin
                bpix_d = bpix_q + 16'd1;
            end
        end

        // Bayer site: even row G/R, odd row B/G.
        c = ~bar_d;
        case ({y_d[0], cnt_d[0]})
            2'b00:   site_on = c[1];
            2'b01:   site_on = c[2];
            2'b10:   site_on = c[0];
            default: site_on = c[1];
        endcase

        case (pat_q)
            2'd0:    pix = site_on ? 10'h3FF : 10'h000;
            2'd1:    pix = cnt_d[9:0];
            2'd2:    pix = (cnt_d[6] ^ y_d[6]) ? 10'h3FF : 10'h000;
            default: pix = cst_q;
        endcase

        lval_d = (state_d == LINE);
        data_d = lval_d ? pix : 10'h000;
        fval_d = (state_d == FRONT) || (state_d == LINE) ||
                 (state_d == HBLANK) || (state_d == BACK);
        busy_d = (state_d != IDLE);

`ifdef CCD_EMU_CHECKSUM_EN
        acc_d  = acc_q;
        csum_d = csum_q;
        csv_d  = frame_end;
        if (state_d == FRONT && state_q != FRONT) acc_d = 16'd0;
        else if (lval_d)                          acc_d = acc_q + {6'd0, data_d};
        if (frame_end) csum_d = acc_q;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            y_q     <= 16'd0;
            bar_q   <= 3'd0;
            bpix_q  <= 16'd0;
            pat_q   <= 2'd0;
            cst_q   <= 10'd0;
            data_q  <= 10'd0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= 32'd0;
`ifdef CCD_EMU_CHECKSUM_EN
            acc_q   <= 16'd0;
            csum_q  <= 16'd0;
            csv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            bar_q   <= bar_d;
            bpix_q  <= bpix_d;
            pat_q   <= pat_d;
            cst_q   <= cst_d;
            data_q  <= data_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
`ifdef CCD_EMU_CHECKSUM_EN
            acc_q   <= acc_d;
            csum_q  <= csum_d;
            csv_q   <= csv_d;
`endif
        end
    end

    assign oDATA       = data_q;
    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oBusy       = busy_q;
    assign oFrame_Cont = fcnt_q;
`ifdef CCD_EMU_CHECKSUM_EN
    assign oChecksum       = csum_q;
    assign oChecksum_Valid = csv_q;
`endif
endmodule

// File: tb/tb_ccd_sensor_emulator.sv
// tb/tb_ccd_sensor_emulator.sv - self-checking bench for ccd_sensor_emulator
module tb_ccd_sensor_emulator;
    localparam int HA = 16, HB = 4, VA = 4, VB = 2, FL = 3, FT = 3;
    localparam int FV_EXP = FL + VA * HA + (VA - 1) * HB + FT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pat;
    logic [9:0]  cst;
    logic [9:0]  data;
    logic        fval, lval, busy;
    logic [31:0] fcnt;
`ifdef CCD_EMU_CHECKSUM_EN
    logic [15:0] csum;
    logic        csum_v;
`endif

    ccd_sensor_emulator #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .V_BLANK(VB), .FV_LEAD(FL), .FV_TRAIL(FT)
    ) dut (
        .Clk(clk), .Reset(rst), .iEnable(en), .iPattern(pat), .iConst(cst),
        .oDATA(data), .oFVAL(fval), .oLVAL(lval), .oBusy(busy),
`ifdef CCD_EMU_CHECKSUM_EN
        .oChecksum(csum), .oChecksum_Valid(csum_v),
`endif
        .oFrame_Cont(fcnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  exp_q[$];
    logic [15:0] exp_sum;
    int          low_len, fv_len;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] model_pix(input int p, input int x, input int y, input logic [9:0] k);
        logic [2:0] b;
        logic [2:0] cc;
        logic       on;
        b  = 3'(x / (HA / 8));
        cc = ~b;
        if (y % 2 == 0) on = (x % 2 == 0) ? cc[1] : cc[2];
        else            on = (x % 2 == 0) ? cc[0] : cc[1];
        case (p)
            0:       return on ? 10'h3FF : 10'h000;
            1:       return 10'(x % 1024);
            2:       return ((((x >> 6) ^ (y >> 6)) & 1) != 0) ? 10'h3FF : 10'h000;
            default: return k;
        endcase
    endfunction

    task automatic push_frame(input int p, input logic [9:0] k);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                exp_q.push_back(model_pix(p, x, y, k));
    endtask

    // Called at a negedge where oFVAL is low; returns at the negedge where it has fallen again.
    task automatic watch_frame(input int poke_at, input logic [9:0] poke_c, input logic poke_en);
        int guard, lines, lv_total, shape_err, blank_err, run, gap;
        logic prev_lv, seen_line;
        logic [9:0] e;
        low_len = 1; fv_len = 0; guard = 0; exp_sum = 16'd0;
        lines = 0; lv_total = 0; shape_err = 0; blank_err = 0; run = 0; gap = 0;
        prev_lv = 1'b0; seen_line = 1'b0;
        while (fval !== 1'b1 && guard < 300) begin
            @(negedge clk);
            if (fval !== 1'b1) low_len++;
            guard++;
        end
        if (guard >= 300) begin
            check("fval_rise_timeout", 32'd0, 32'd1);
            return;
        end
        while (fval === 1'b1 && fv_len < 400) begin
            if (fv_len == poke_at) begin
                cst = poke_c;
                en  = poke_en;
            end
            if (lval === 1'b1) begin
                if (!prev_lv) begin
                    lines++;
                    if (seen_line && gap != HB) shape_err++;
                    run = 0;
                end
                run++;
                lv_total++;
                if (exp_q.size() == 0) check("pix_underflow", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    exp_sum = exp_sum + {6'd0, e};
                    check("pix", {22'd0, data}, {22'd0, e});
                end
            end else begin
                if (prev_lv) begin
                    if (run != HA) shape_err++;
                    seen_line = 1'b1;
                    gap = 0;
                end
                gap++;
                if (data !== 10'h000) blank_err++;
            end
`ifdef CCD_EMU_CHECKSUM_EN
            if (csum_v !== 1'b0) blank_err++;
`endif
            prev_lv = lval;
            fv_len++;
            @(negedge clk);
        end
        if (prev_lv) shape_err++;
        if (lval !== 1'b0 || data !== 10'h000) blank_err++;
        check("fval_len", fv_len, FV_EXP);
        check("lval_pulses", lines, VA);
        check("lval_total", lv_total, VA * HA);
        check("line_shape", shape_err, 0);
        check("blank_data", blank_err, 0);
        check("queue_left", exp_q.size(), 0);
    endtask

    task automatic check_csum(input string tag);
`ifdef CCD_EMU_CHECKSUM_EN
        check({tag, "_csum_valid"}, {31'd0, csum_v}, 32'd1);
        check({tag, "_csum"}, {16'd0, csum}, {16'd0, exp_sum});
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        int viol;
        rst = 1'b1; en = 1'b0; pat = 2'd1; cst = 10'h000;
        repeat (3) @(negedge clk);
        check("rst_data", {22'd0, data}, 32'd0);
        check("rst_fval", {31'd0, fval}, 32'd0);
        check("rst_lval", {31'd0, lval}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fcnt", fcnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame A: ramp, streaming.
        push_frame(1, 10'h000);
        en = 1'b1;
        watch_frame(-1, 10'h000, 1'b1);
        check("A_fcnt", fcnt, 32'd1);
        check("A_busy_vblank", {31'd0, busy}, 32'd1);
        check_csum("A");

        // Frame B: ramp again; inter-frame gap measured.
        push_frame(1, 10'h000);
        watch_frame(-1, 10'h000, 1'b1);
        check("B_low_len", low_len, VB * (HA + HB));
        check("B_period", low_len + fv_len, 122);
        check("B_fcnt", fcnt, 32'd2);
        check_csum("B");
`ifdef CCD_EMU_CHECKSUM_EN
        check("B_csum_const", {16'd0, csum}, 32'h01E0);
        @(negedge clk);
        check("B_csum_pulse_width", {31'd0, csum_v}, 32'd0);
`endif

        // Frame C: colour bars.
        pat = 2'd0;
        push_frame(0, 10'h000);
        watch_frame(-1, 10'h000, 1'b1);
        check("C_fcnt", fcnt, 32'd3);
        check_csum("C");

        // Frame D: constant 155, iConst changed mid-frame.
        pat = 2'd3; cst = 10'h155;
        push_frame(3, 10'h155);
        watch_frame(20, 10'h2AA, 1'b1);
        check("D_fcnt", fcnt, 32'd4);
        check_csum("D");

        // Frame E: constant 2AA, iEnable dropped during line 1.
        push_frame(3, 10'h2AA);
        watch_frame(30, 10'h2AA, 1'b0);
        check("E_fcnt", fcnt, 32'd5);
        check("E_busy_idle", {31'd0, busy}, 32'd0);
        check_csum("E");
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (fval !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("E_stays_idle", viol, 0);

        // Reset pulse mid-line, then a clean frame.
        pat = 2'd1;
        en  = 1'b1;
        viol = 0;
        while (fval !== 1'b1 && viol < 100) begin
            @(negedge clk);
            viol++;
        end
        repeat (8) @(negedge clk);
        check("pre_rst_lval", {31'd0, lval}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_fval", {31'd0, fval}, 32'd0);
        check("mid_rst_lval", {31'd0, lval}, 32'd0);
        check("mid_rst_data", {22'd0, data}, 32'd0);
        check("mid_rst_fcnt", fcnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_frame(1, 10'h000);
        watch_frame(-1, 10'h000, 1'b1);
        check("R_fcnt", fcnt, 32'd1);
        check_csum("R");

        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
